// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared bus widths, CSR addresses and trap sequencer types
//
// Contents:
//   RegBus / MemAddrBus      data and address widths
//   CSR_MSTATUS/MEPC/MCAUSE  machine-mode CSR addresses used by the trap sequencer
//   INST_ECALL/EBREAK/MRET   full 32-bit encodings recognised in decode
//   CAUSE_ECALL/EBREAK       synchronous exception cause codes
//   trap_state_e             trap sequencer states
//   mstatus_on_trap/mret     mstatus rewrite helpers (MIE/MPIE stacking)
package tinyriscv_pkg;

    localparam int RegBus     = 32;
    localparam int MemAddrBus = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [RegBus-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [RegBus-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [RegBus-1:0] INST_MRET   = 32'h3020_0073;

    localparam logic [RegBus-1:0] CAUSE_ECALL  = 32'd11;
    localparam logic [RegBus-1:0] CAUSE_EBREAK = 32'd3;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        W_MRET,
        ASSERT
    } trap_state_e;

    // Zero-extend a 12-bit CSR address onto the clint address bus.
    function automatic logic [MemAddrBus-1:0] csr_addr(input logic [11:0] a);
        return {{(MemAddrBus-12){1'b0}}, a};
    endfunction

    // Trap entry: MPIE <= MIE, MIE <= 0.
    function automatic logic [RegBus-1:0] mstatus_on_trap(input logic [RegBus-1:0] ms);
        return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1.
    function automatic logic [RegBus-1:0] mstatus_on_mret(input logic [RegBus-1:0] ms);
        return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - machine-mode trap sequencer (ecall/ebreak/mret/timer IRQ)
//
// Stalls the pipeline, writes mepc/mstatus/mcause one per cycle through the
// clint CSR write port, then pulses a one-cycle redirect to mtvec or mepc.
//
// Optional build macro: VECTORED_MTVEC_EN
//   defined   - interrupts with mtvec[1:0]==2'b01 go to base + VEC_STRIDE*cause[30:0]
//   undefined - mtvec[1:0] ignored, every trap goes to base
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   inst_i, inst_addr_i           instruction in decode and its address
//   jump_flag_i, jump_addr_i      ex redirect in progress and its target
//   div_busy_i                    multicycle divide in flight (blocks IRQ only)
//   irq_i, global_int_en_i        level timer interrupt, mstatus.MIE
//   csr_mtvec_i/mepc_i/mstatus_i  current CSR values from csr_reg
//   clint_we_o/waddr_o/data_o     CSR write port (registered)
//   clint_raddr_o                 CSR read address, tied 0
//   hold_flag_o                   pipeline stall
//   int_assert_o, int_addr_o      one-cycle redirect strobe and target
import tinyriscv_pkg::*;

module csr_trap_ctrl #(
    parameter logic [RegBus-1:0] TIMER_CAUSE = 32'h8000_0007
`ifdef VECTORED_MTVEC_EN
    ,
    parameter int unsigned       VEC_STRIDE  = 4
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [RegBus-1:0]     inst_i,
    input  logic [MemAddrBus-1:0] inst_addr_i,
    input  logic                  jump_flag_i,
    input  logic [MemAddrBus-1:0] jump_addr_i,
    input  logic                  div_busy_i,
    input  logic                  irq_i,
    input  logic                  global_int_en_i,
    input  logic [RegBus-1:0]     csr_mtvec_i,
    input  logic [RegBus-1:0]     csr_mepc_i,
    input  logic [RegBus-1:0]     csr_mstatus_i,
    output logic                  clint_we_o,
    output logic [MemAddrBus-1:0] clint_waddr_o,
    output logic [MemAddrBus-1:0] clint_raddr_o,
    output logic [RegBus-1:0]     clint_data_o,
    output logic                  hold_flag_o,
    output logic                  int_assert_o,
    output logic [MemAddrBus-1:0] int_addr_o
);

    trap_state_e           state_q;
    logic [MemAddrBus-1:0] epc_q;
    logic [RegBus-1:0]     cause_q;

    logic                  is_ecall;
    logic                  is_ebreak;
    logic                  is_mret;
    logic                  sync_req;
    logic                  irq_req;
    logic                  accept;
    logic [MemAddrBus-1:0] irq_epc;
    logic [MemAddrBus-1:0] trap_target;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    assign sync_req  = is_ecall | is_ebreak;
    // A divide in flight cannot be abandoned safely, so the interrupt waits.
    assign irq_req   = irq_i & global_int_en_i & ~div_busy_i;

    // Gated by reset so the stall is also low while reset is held.
    assign accept      = rst_ni & (state_q == IDLE) & (sync_req | is_mret | irq_req);
    assign hold_flag_o = (state_q != IDLE) | accept;

    // If ex is redirecting, the instruction in decode is on the wrong path;
    // resume at the jump target instead.
    assign irq_epc = jump_flag_i ? jump_addr_i : inst_addr_i;

    assign clint_raddr_o = '0;

`ifdef VECTORED_MTVEC_EN
    always_comb begin
        trap_target = {csr_mtvec_i[31:2], 2'b00};
        if (cause_q[31] && (csr_mtvec_i[1:0] == 2'b01)) begin
            trap_target = {csr_mtvec_i[31:2], 2'b00}
                        + (32'(VEC_STRIDE) * {1'b0, cause_q[30:0]});
        end
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
    assign trap_target       = {csr_mtvec_i[31:2], 2'b00};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            epc_q         <= '0;
            cause_q       <= '0;
            clint_we_o    <= 1'b0;
            clint_waddr_o <= '0;
            clint_data_o  <= '0;
            int_assert_o  <= 1'b0;
            int_addr_o    <= '0;
        end else begin
            clint_we_o    <= 1'b0;
            clint_waddr_o <= '0;
            clint_data_o  <= '0;
            int_assert_o  <= 1'b0;
            int_addr_o    <= '0;
            case (state_q)
                IDLE: begin
                    // Priority: ecall/ebreak > mret > irq.
                    if (sync_req) begin
                        epc_q         <= inst_addr_i;
                        cause_q       <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        clint_we_o    <= 1'b1;
                        clint_waddr_o <= csr_addr(CSR_MEPC);
                        clint_data_o  <= inst_addr_i;
                        state_q       <= W_MEPC;
                    end else if (is_mret) begin
                        clint_we_o    <= 1'b1;
                        clint_waddr_o <= csr_addr(CSR_MSTATUS);
                        clint_data_o  <= mstatus_on_mret(csr_mstatus_i);
                        state_q       <= W_MRET;
                    end else if (irq_req) begin
                        epc_q         <= irq_epc;
                        cause_q       <= TIMER_CAUSE;
                        clint_we_o    <= 1'b1;
                        clint_waddr_o <= csr_addr(CSR_MEPC);
                        clint_data_o  <= irq_epc;
                        state_q       <= W_MEPC;
                    end
                end
                W_MEPC: begin
                    clint_we_o    <= 1'b1;
                    clint_waddr_o <= csr_addr(CSR_MSTATUS);
                    clint_data_o  <= mstatus_on_trap(csr_mstatus_i);
                    state_q       <= W_MSTATUS;
                end
                W_MSTATUS: begin
                    clint_we_o    <= 1'b1;
                    clint_waddr_o <= csr_addr(CSR_MCAUSE);
                    clint_data_o  <= cause_q;
                    state_q       <= W_MCAUSE;
                end
                W_MCAUSE: begin
                    int_assert_o <= 1'b1;
                    int_addr_o   <= trap_target;
                    state_q      <= ASSERT;
                end
                W_MRET: begin
                    int_assert_o <= 1'b1;
                    int_addr_o   <= csr_mepc_i;
                    state_q      <= ASSERT;
                end
                ASSERT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - directed table-driven bench for csr_trap_ctrl
module tb_csr_trap_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst, inst_addr, jump_addr, mtvec, mepc, mstatus;
    logic        jump_flag, div_busy, irq, gie;
    logic        we, hold, int_assert;
    logic [31:0] waddr, raddr, wdata, int_addr;

    int checks   = 0;
    int failures = 0;

    csr_trap_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .inst_i          (inst),
        .inst_addr_i     (inst_addr),
        .jump_flag_i     (jump_flag),
        .jump_addr_i     (jump_addr),
        .div_busy_i      (div_busy),
        .irq_i           (irq),
        .global_int_en_i (gie),
        .csr_mtvec_i     (mtvec),
        .csr_mepc_i      (mepc),
        .csr_mstatus_i   (mstatus),
        .clint_we_o      (we),
        .clint_waddr_o   (waddr),
        .clint_raddr_o   (raddr),
        .clint_data_o    (wdata),
        .hold_flag_o     (hold),
        .int_assert_o    (int_assert),
        .int_addr_o      (int_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] ia;
        logic        jf;
        logic [31:0] ja;
        logic        div;
        logic        irq;
        logic        gie;
        logic [31:0] ms;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        taken;
        logic        mret;
        logic [31:0] epc;
        logic [31:0] ms_wr;
        logic [31:0] cause;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        inst      = NOP;
        irq       = 1'b0;
        jump_flag = 1'b0;
        div_busy  = 1'b0;
    endtask

    // Entered at the negedge of the accept cycle; walks the whole sequence.
    task automatic expect_seq(input string tag, input bit is_ret, input logic [31:0] epc,
                              input logic [31:0] ms_wr, input logic [31:0] cause,
                              input logic [31:0] addr);
        @(posedge clk);
        #1 clear_req();
        @(negedge clk);
        if (is_ret) begin
            chk({tag, ".c1_we"},    {31'd0, we},   32'd1);
            chk({tag, ".c1_waddr"}, waddr,         32'h300);
            chk({tag, ".c1_data"},  wdata,         ms_wr);
            chk({tag, ".c1_hold"},  {31'd0, hold}, 32'd1);
            @(negedge clk);
            chk({tag, ".c2_assert"}, {31'd0, int_assert}, 32'd1);
            chk({tag, ".c2_addr"},   int_addr,            addr);
            chk({tag, ".c2_we"},     {31'd0, we},         32'd0);
            @(negedge clk);
            chk({tag, ".c3_hold"},   {31'd0, hold},       32'd0);
            chk({tag, ".c3_assert"}, {31'd0, int_assert}, 32'd0);
        end else begin
            chk({tag, ".c1_we"},    {31'd0, we},   32'd1);
            chk({tag, ".c1_waddr"}, waddr,         32'h341);
            chk({tag, ".c1_data"},  wdata,         epc);
            chk({tag, ".c1_hold"},  {31'd0, hold}, 32'd1);
            @(negedge clk);
            chk({tag, ".c2_we"},    {31'd0, we},   32'd1);
            chk({tag, ".c2_waddr"}, waddr,         32'h300);
            chk({tag, ".c2_data"},  wdata,         ms_wr);
            @(negedge clk);
            chk({tag, ".c3_we"},    {31'd0, we},   32'd1);
            chk({tag, ".c3_waddr"}, waddr,         32'h342);
            chk({tag, ".c3_data"},  wdata,         cause);
            @(negedge clk);
            chk({tag, ".c4_assert"}, {31'd0, int_assert}, 32'd1);
            chk({tag, ".c4_addr"},   int_addr,            addr);
            chk({tag, ".c4_we"},     {31'd0, we},         32'd0);
            chk({tag, ".c4_hold"},   {31'd0, hold},       32'd1);
            @(negedge clk);
            chk({tag, ".c5_hold"},   {31'd0, hold},       32'd0);
            chk({tag, ".c5_assert"}, {31'd0, int_assert}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".we"},     {31'd0, we},         32'd0);
        chk({tag, ".waddr"},  waddr,               32'd0);
        chk({tag, ".raddr"},  raddr,               32'd0);
        chk({tag, ".data"},   wdata,               32'd0);
        chk({tag, ".hold"},   {31'd0, hold},       32'd0);
        chk({tag, ".assert"}, {31'd0, int_assert}, 32'd0);
        chk({tag, ".addr"},   int_addr,            32'd0);
    endtask

    initial begin
        logic [31:0] vec_irq_addr;
`ifdef VECTORED_MTVEC_EN
        vec_irq_addr = 32'h21C;
`else
        vec_irq_addr = 32'h200;
`endif
        //           inst    ia        jf    ja       div   irq   gie   ms            mtvec     mepc      taken mret  epc       ms_wr         cause         addr
        vecs[0]  = '{ECALL,  32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h08,       32'h200,  32'h0,    1'b1, 1'b0, 32'h100,  32'h80,       32'd11,       32'h200};
        vecs[1]  = '{EBREAK, 32'h140, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h1808,     32'h203,  32'h0,    1'b1, 1'b0, 32'h140,  32'h1880,     32'd3,        32'h200};
        vecs[2]  = '{MRET,   32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h80,       32'h200,  32'h104,  1'b1, 1'b1, 32'h0,    32'h88,       32'h0,        32'h104};
        vecs[3]  = '{MRET,   32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'hFFFFFF7F, 32'h200,  32'h500,  1'b1, 1'b1, 32'h0,    32'hFFFFFFF7, 32'h0,        32'h500};
        vecs[4]  = '{NOP,    32'h400, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h08,       32'h200,  32'h0,    1'b1, 1'b0, 32'h300,  32'h80,       32'h80000007, 32'h200};
        vecs[5]  = '{NOP,    32'h208, 1'b0, 32'h300, 1'b0, 1'b1, 1'b1, 32'h88,       32'h200,  32'h0,    1'b1, 1'b0, 32'h208,  32'h80,       32'h80000007, 32'h200};
        vecs[6]  = '{NOP,    32'h208, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h00,       32'h200,  32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        32'h0,        32'h0};
        vecs[7]  = '{NOP,    32'h208, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h08,       32'h200,  32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        32'h0,        32'h0};
        vecs[8]  = '{ECALL,  32'h600, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h08,       32'h3FC,  32'h0,    1'b1, 1'b0, 32'h600,  32'h80,       32'd11,       32'h3FC};
        vecs[9]  = '{ECALL,  32'h700, 1'b1, 32'h900, 1'b0, 1'b1, 1'b1, 32'h08,       32'h200,  32'h0,    1'b1, 1'b0, 32'h700,  32'h80,       32'd11,       32'h200};
        vecs[10] = '{MRET,   32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h80,       32'h200,  32'h104,  1'b1, 1'b1, 32'h0,    32'h88,       32'h0,        32'h104};
        vecs[11] = '{NOP,    32'h800, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h08,       32'h201,  32'h0,    1'b1, 1'b0, 32'h800,  32'h80,       32'h80000007, vec_irq_addr};
        vecs[12] = '{EBREAK, 32'h840, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h201,  32'h0,    1'b1, 1'b0, 32'h840,  32'hFFFFFFF7, 32'd3,        32'h200};

        rst_n = 1'b0;
        clear_req();
        inst_addr = '0; jump_addr = '0; gie = 1'b0;
        mtvec = '0; mepc = '0; mstatus = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            inst = vecs[i].inst; inst_addr = vecs[i].ia;
            jump_flag = vecs[i].jf; jump_addr = vecs[i].ja;
            div_busy = vecs[i].div; irq = vecs[i].irq; gie = vecs[i].gie;
            mstatus = vecs[i].ms; mtvec = vecs[i].mtvec; mepc = vecs[i].mepc;
            #1;
            chk($sformatf("vec%0d.c0_hold", i), {31'd0, hold}, {31'd0, vecs[i].taken});
            if (vecs[i].taken) begin
                expect_seq($sformatf("vec%0d", i), vecs[i].mret, vecs[i].epc,
                           vecs[i].ms_wr, vecs[i].cause, vecs[i].addr);
            end else begin
                @(posedge clk);
                #1 clear_req();
                @(negedge clk);
                chk($sformatf("vec%0d.idle_hold", i), {31'd0, hold}, 32'd0);
                chk($sformatf("vec%0d.idle_we", i),   {31'd0, we},   32'd0);
            end
        end

        // IRQ held off by a 5-cycle divide, taken as soon as it drops.
        inst = NOP; inst_addr = 32'h900; irq = 1'b1; gie = 1'b1; div_busy = 1'b1;
        mstatus = 32'h08; mtvec = 32'h200;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("div.wait%0d_hold", c), {31'd0, hold}, 32'd0);
            chk($sformatf("div.wait%0d_we", c),   {31'd0, we},   32'd0);
            @(negedge clk);
        end
        div_busy = 1'b0;
        #1 chk("div.accept_hold", {31'd0, hold}, 32'd1);
        expect_seq("div", 1'b0, 32'h900, 32'h80, 32'h80000007, 32'h200);

        // ecall beats a simultaneous IRQ; IRQ stays pending until MIE returns.
        inst = ECALL; inst_addr = 32'hA00; irq = 1'b1; gie = 1'b1;
        #1 chk("race.c0_hold", {31'd0, hold}, 32'd1);
        expect_seq("race", 1'b0, 32'hA00, 32'h80, 32'd11, 32'h200);
        irq = 1'b1; gie = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("race.masked%0d_hold", c), {31'd0, hold}, 32'd0);
            @(negedge clk);
        end
        gie = 1'b1;
        #1 chk("race.reenable_hold", {31'd0, hold}, 32'd1);
        expect_seq("reen", 1'b0, 32'hA00, 32'h80, 32'h80000007, 32'h200);

        // Reset pulsed while in W_MSTATUS.
        inst = ECALL; inst_addr = 32'hB00; mstatus = 32'h08; mtvec = 32'h200;
        #1 chk("rst.c0_hold", {31'd0, hold}, 32'd1);
        @(posedge clk);
        #1 clear_req();
        @(negedge clk);
        @(negedge clk);
        chk("rst.pre_we", {31'd0, we}, 32'd1);
        rst_n = 1'b0;
        #1 check_all_zero("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rst.after%0d_assert", c), {31'd0, int_assert}, 32'd0);
            chk($sformatf("rst.after%0d_hold", c),   {31'd0, hold},       32'd0);
            chk($sformatf("rst.after%0d_we", c),     {31'd0, we},         32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
